// File: rtl/reveal_engine.sv
// Minesweeper click/reveal stage: loads an 8x8 board, serves one click at a time,
// flood-fills zero-count regions through a 64-entry index FIFO, and tracks loss/win.
//
// state   | meaning
// IDLE    | waiting for a click (ready unless the game has ended)
// CHECK   | apply the latched click to its target cell
// POP     | take the next zero-count cell from the FIFO, or finish
// SCAN    | visit one neighbour per cycle, k = N, NE, E, SE, S, SW, W, NW
// DONE    | pulse done, evaluate the win condition
module reveal_engine (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [0:7][0:7][7:0]  board_in,
  input  logic [6:0]            bomb_total,
  input  logic                  click_valid,
  input  logic [2:0]            click_row,
  input  logic [2:0]            click_col,
  input  logic                  click_flag,
  output logic                  click_ready,
  output logic [0:7][0:7][7:0]  board_out,
  output logic [6:0]            revealed_count,
  output logic                  done,
  output logic                  game_over,
  output logic                  game_won
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_POP, S_SCAN, S_DONE} state_t;

  state_t                 state_q;
  logic [0:7][0:7][7:0]   board_q;
  logic [6:0]             bomb_total_q;
  logic [6:0]             revealed_q;
  logic                   done_q;
  logic                   over_q;
  logic                   won_q;
  logic [2:0]             row_q;
  logic [2:0]             col_q;
  logic                   flag_q;
  logic [2:0]             k_q;
  logic [5:0]             fifo_q [0:63];
  logic [5:0]             head_q;
  logic [5:0]             tail_q;
  logic [6:0]             fcnt_q;

  logic [7:0] cell_d;
  logic [7:0] nb_cell_d;
  logic [4:0] dr_d, dc_d, nr_d, nc_d;
  logic [2:0] nb_r_d, nb_c_d;
  logic       nb_in_d;
  logic       nb_take_d;
  logic       chk_open_d;
  logic       push_en_d;
  logic [5:0] push_data_d;
  logic       unused_bits;

  // Row/col deltas are 5-bit two's complement so an out-of-range neighbour shows in bits [4:3].
  always_comb begin
    dr_d = 5'd0;
    dc_d = 5'd0;
    case (k_q)
      3'd0: dr_d = 5'h1f;
      3'd1: begin dr_d = 5'h1f; dc_d = 5'd1;  end
      3'd2: dc_d = 5'd1;
      3'd3: begin dr_d = 5'd1;  dc_d = 5'd1;  end
      3'd4: dr_d = 5'd1;
      3'd5: begin dr_d = 5'd1;  dc_d = 5'h1f; end
      3'd6: dc_d = 5'h1f;
      default: begin dr_d = 5'h1f; dc_d = 5'h1f; end
    endcase
    nr_d        = {2'b00, row_q} + dr_d;
    nc_d        = {2'b00, col_q} + dc_d;
    nb_r_d      = nr_d[2:0];
    nb_c_d      = nc_d[2:0];
    nb_in_d     = (nr_d[4:3] == 2'b00) && (nc_d[4:3] == 2'b00);
    nb_cell_d   = board_q[nb_r_d][nb_c_d];
    cell_d      = board_q[row_q][col_q];
    nb_take_d   = (state_q == S_SCAN) && nb_in_d &&
                  !nb_cell_d[6] && !nb_cell_d[7] && !nb_cell_d[5];
    chk_open_d  = (state_q == S_CHECK) && !flag_q &&
                  !cell_d[6] && !cell_d[7] && !cell_d[5];
    push_en_d   = (chk_open_d && (cell_d[3:0] == 4'd0)) ||
                  (nb_take_d && (nb_cell_d[3:0] == 4'd0));
    push_data_d = chk_open_d ? {row_q, col_q} : {nb_r_d, nb_c_d};
  end

  always_comb begin
    unused_bits = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        unused_bits = unused_bits ^ (^{board_in[r][c][7:6], board_in[r][c][4]});
  end

  always_ff @(posedge clk) begin
    if (push_en_d) fifo_q[tail_q] <= push_data_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      board_q      <= '0;
      bomb_total_q <= '0;
      revealed_q   <= '0;
      done_q       <= 1'b0;
      over_q       <= 1'b0;
      won_q        <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      flag_q       <= 1'b0;
      k_q          <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      fcnt_q       <= '0;
    end else if (load) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          board_q[r][c] <= {2'b00, board_in[r][c][5], 1'b0, board_in[r][c][3:0]};
      bomb_total_q <= bomb_total;
      revealed_q   <= '0;
      done_q       <= 1'b0;
      over_q       <= 1'b0;
      won_q        <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      fcnt_q       <= '0;
      state_q      <= S_IDLE;
    end else begin
      done_q <= 1'b0;
      if (push_en_d) begin
        tail_q <= tail_q + 6'd1;
        fcnt_q <= fcnt_q + 7'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (click_valid && click_ready) begin
            row_q   <= click_row;
            col_q   <= click_col;
            flag_q  <= click_flag;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          if (flag_q) begin
            if (!cell_d[6]) board_q[row_q][col_q][7] <= ~cell_d[7];
          end else if (!cell_d[6] && !cell_d[7]) begin
            board_q[row_q][col_q][6] <= 1'b1;
            if (cell_d[5]) begin
              over_q <= 1'b1;
            end else begin
              revealed_q <= revealed_q + 7'd1;
              if (cell_d[3:0] == 4'd0) begin
                state_q <= S_POP;
                done_q  <= 1'b0;
              end
            end
          end
        end
        S_POP: begin
          if (fcnt_q == 7'd0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            {row_q, col_q} <= fifo_q[head_q];
            head_q  <= head_q + 6'd1;
            fcnt_q  <= fcnt_q - 7'd1;
            k_q     <= 3'd0;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (nb_take_d) begin
            board_q[nb_r_d][nb_c_d][6] <= 1'b1;
            revealed_q <= revealed_q + 7'd1;
          end
          k_q <= k_q + 3'd1;
          if (k_q == 3'd7) state_q <= S_POP;
        end
        S_DONE: begin
          if (!over_q && (revealed_q == 7'd64 - bomb_total_q)) won_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign click_ready    = (state_q == S_IDLE) && !over_q && !won_q;
  assign board_out      = board_q;
  assign revealed_count = revealed_q;
  assign done           = done_q;
  assign game_over      = over_q;
  assign game_won       = won_q;

endmodule

// File: doc/reveal_engine.md
# reveal_engine

Click-driven cell reveal stage for the 8x8 minesweeper board, sitting directly downstream of bomb placement/neighbour counting. It loads the finished board (bomb flags plus neighbour counts) and serves player clicks one at a time. On each click it reveals or flags a cell, flood-fills zero-count regions through an internal 64-entry FIFO, and tracks loss and win conditions. `board_out` drives the display stage.

## Interface
- No parameters; board fixed at 8x8.
- Reset: rst, asynchronous, active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  async active-high reset
- `load`  in  1  one-cycle pulse; latch `board_in` into internal board
- `board_in`  in  8 x [0:7][0:7]  upstream board: [3:0] neighbour count 0..8, [5] bomb; other bits ignored
- `bomb_total`  in  7  number of bombs on loaded board (0..63), sampled at load
- `click_valid`  in  1  click request
- `click_row`, `click_col`  in  3 each  target cell
- `click_flag`  in  1  1 = toggle flag, 0 = reveal
- `click_ready`  out  1  high when a click can be accepted
- `board_out`  out  8 x [0:7][0:7]  internal board: [3:0] count, [5] bomb, [6] revealed, [7] flagged
- `revealed_count`  out  7  revealed non-bomb cells
- `done`  out  1  one-cycle pulse at end of each accepted click
- `game_over`  out  1  sticky, bomb revealed
- `game_won`  out  1  sticky, all non-bomb cells revealed

## Operation
- Load: board bits [5] and [3:0] copied from `board_in`; bits [4], [6] and [7] cleared. `bomb_total` is registered. `revealed_count`, `game_over`, `game_won` and the FIFO are cleared. FSM goes to IDLE.
- `load` has priority in every state and aborts any click in progress.
- FSM states: IDLE, CHECK, POP, SCAN, DONE.
- IDLE: `click_ready` = 1 when neither `game_over` nor `game_won` is set. On `click_valid && click_ready`, register row, col and flag, then go to CHECK.
- CHECK, flag op: toggle [7] if the cell is unrevealed; go to DONE. A revealed cell is left unchanged.
- CHECK, reveal op:
  - Cell revealed or flagged: no change; go to DONE.
  - Cell is a bomb: set [6] and `game_over`; go to DONE.
  - Otherwise: set [6] and increment `revealed_count`. If count = 0, push the cell index {row,col} and go to POP; else go to DONE.
- POP: FIFO empty goes to DONE. Otherwise pop one index, set neighbour counter k = 0, go to SCAN.
- SCAN: one neighbour per cycle, k = 0..7 in order N, NE, E, SE, S, SW, W, NW.
  - Skip the neighbour if it is out of bounds, revealed, flagged, or a bomb.
  - Otherwise set [6] and increment `revealed_count`; if its count is 0, push it.
  - After k = 7, go to POP.
- A cell is marked revealed at push time, so each cell is pushed at most once; 64 entries never overflow.
- DONE: pulse `done`; set `game_won` if `!game_over` and `revealed_count == 64 - bomb_total`; go to IDLE.
- Clicks are not queued. `click_valid` while `click_ready` = 0 is ignored.

## Timing
- Reset values: board all 0, `revealed_count` 0, `done` 0, `game_over` 0, `game_won` 0, `click_ready` 1, FIFO empty, state IDLE.
- Accept edge = T. CHECK occupies cycle T+1.
- Non-cascading click (including flag, ignored and bomb clicks): `done` high in cycle T+2; `click_ready` returns high in T+3.
- Cascading click with P pushed cells: `done` high in cycle T+3+9P.
- `board_out` and `revealed_count` update on the edge closing the cycle that modifies them. Both are final when `done` is high.
- `game_won` is visible the cycle after `done`.
- Reset or `load` mid-cascade: FIFO discarded, no `done` pulse; reset clears the board, load replaces it.
- `bomb_total` = 0 and a click on any zero-count cell reveals all 64 cells and sets `game_won`.

## Test plan
- Count-2 cell, reveal at (3,4): `done` at T+2, cell [6] = 1, `revealed_count` = 1, no other cell changes.
- Bomb at (2,2), reveal click on it: `game_over` = 1, `done` at T+2, `click_ready` stays 0 until `load`.
- Single bomb at (0,0), `bomb_total` = 1, reveal at (7,7):
  - 63 cells revealed, (0,0) unrevealed, `revealed_count` = 63, `game_won` = 1.
  - `done` at T+3+9*60 = T+543.
- Flag (5,5), then reveal (5,5): cell unchanged; `done` at T+2 both times. Flag again: [7] cleared.
- Flag (0,0) on an empty board (`bomb_total` = 0), then reveal (7,7): flood stops at the flag; 63 cells revealed, `game_won` not set.
- Assert rst 20 cycles into the (7,7) cascade: all outputs return to reset values immediately, and no `done` pulse occurs. Repeat using `load` instead: the board equals `board_in` with [6] and [7] cleared, and the FSM is in IDLE.
